// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, sizes and helpers for the keypad scanner.
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_e;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int KEY_W = 4;
  localparam int PENDING_BIT = 7;
  localparam int OVERFLOW_BIT = 6;
  // Lowest-index low column wins when several are pressed.
  function automatic logic [1:0] col_enc(input logic [COLS-1:0] c);
    return !c[0] ? 2'd0 : !c[1] ? 2'd1 : !c[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/col_synchronizer.sv
// col_synchronizer: generic two-flop synchroniser with async active-low reset.
module col_synchronizer #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] meta_q, sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end
  assign q_o = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix scan, debounce and single-entry keypress register.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [COLS-1:0] cols,
  output logic [ROWS-1:0] rows,
  input  logic            rd_ack,
  output logic [7:0]      filtered_out,
  output logic            key_down
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CYCLES);
  localparam int RW = $clog2(ROWS);
  localparam logic [DW-1:0] DWELL_END = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DB_END = BW'(DEBOUNCE_CYCLES - 1);
  localparam logic [COLS-1:0] IDLE = '1;
  state_e state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [BW-1:0] db_q, db_d;
  logic [COLS-1:0] cand_q, cand_d, cols_s;
  logic [KEY_W-1:0] code_q, code_d;
  logic pend_q, pend_d, ovf_q, ovf_d, accept;
  col_synchronizer #(.WIDTH(COLS), .RST_VAL(4'hF)) u_sync (
    .clk(clk), .rst_n(reset), .d_i(cols), .q_o(cols_s)
  );
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    dwell_d = dwell_q;
    db_d = db_q;
    cand_d = cand_q;
    accept = 1'b0;
    case (state_q)
      SCAN: begin
        dwell_d = (dwell_q == DWELL_END) ? '0 : dwell_q + 1'b1;
        if (dwell_q == DWELL_END && cols_s == IDLE) row_d = row_q + 1'b1;
        if (dwell_q == DWELL_END && cols_s != IDLE) begin
          cand_d = cols_s;
          db_d = '0;
          state_d = PRESS_DB;
        end
      end
      PRESS_DB: begin
        accept = (cols_s == cand_q) && (db_q == DB_END);
        db_d = (cols_s == cand_q && !accept) ? db_q + 1'b1 : db_q;
        dwell_d = '0;
        state_d = (cols_s != cand_q) ? SCAN : accept ? HELD : PRESS_DB;
      end
      HELD: begin
        db_d = '0;
        state_d = (cols_s == IDLE) ? REL_DB : HELD;
      end
      REL_DB: begin
        db_d = db_q + 1'b1;
        if (cols_s != IDLE) state_d = HELD;
        else if (db_q == DB_END) begin
          state_d = SCAN;
          row_d = row_q + 1'b1;
          dwell_d = '0;
        end
      end
      default: state_d = SCAN;
    endcase
  end
  // An accept in the same cycle as rd_ack wins and never flags overflow.
  always_comb begin
    code_d = accept ? {row_q, col_enc(cand_q)} : code_q;
    pend_d = accept | (pend_q & ~rd_ack);
    ovf_d = accept ? (pend_q & ~rd_ack) : (ovf_q & ~rd_ack);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SCAN;
      row_q <= '0;
      dwell_q <= '0;
      db_q <= '0;
      cand_q <= IDLE;
      code_q <= '0;
      pend_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      dwell_q <= dwell_d;
      db_q <= db_d;
      cand_q <= cand_d;
      code_q <= code_d;
      pend_q <= pend_d;
      ovf_q <= ovf_d;
    end
  end
  always_comb begin
    filtered_out = '0;
    filtered_out[PENDING_BIT] = pend_q;
    filtered_out[OVERFLOW_BIT] = ovf_q;
    filtered_out[KEY_W-1:0] = code_q;
  end
  assign rows = ~(4'b0001 << row_q);
  assign key_down = (state_q == HELD) || (state_q == REL_DB);
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized keypad stimulus checked against a behavioural model.
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int DB = 8;
  logic clk = 1'b0, reset, rd_ack;
  logic [3:0] cols, rows;
  logic [7:0] filtered_out;
  logic key_down;
  int n_chk = 0, n_pass = 0, rises = 0;
  logic kd_prev = 1'b0;
  int kr = 0, kc = 0;
  bit kp = 0;
  logic [3:0] m_s1, m_s2, m_cand, m_code;
  int m_row, m_dwell, m_run;
  bit m_trying, m_locked, m_releasing, m_pend, m_ovf, m_acc;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .cols(cols), .rows(rows), .rd_ack(rd_ack),
    .filtered_out(filtered_out), .key_down(key_down)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_s1 = 4'hF; m_s2 = 4'hF; m_cand = 4'hF; m_code = 4'h0;
    m_row = 0; m_dwell = 0; m_run = 0;
    m_trying = 0; m_locked = 0; m_releasing = 0; m_pend = 0; m_ovf = 0;
  endtask

  function automatic int low_col(input logic [3:0] c);
    int idx = 3;
    for (int i = 3; i >= 0; i--) if (!c[i]) idx = i;
    return idx;
  endfunction

  // Advances the scan/debounce behaviour by one clock using the synced columns.
  task automatic model_scan(input logic [3:0] c);
    logic [3:0] cs = m_s2;
    m_acc = 0;
    if (m_trying) begin
      if (cs != m_cand) begin m_trying = 0; m_dwell = 0; end
      else if (m_run == DB - 1) begin m_acc = 1; m_trying = 0; m_locked = 1; m_releasing = 0; end
      else m_run++;
    end else if (m_locked && !m_releasing) begin
      if (cs == 4'hF) begin m_releasing = 1; m_run = 0; end
    end else if (m_locked) begin
      if (cs != 4'hF) m_releasing = 0;
      else if (m_run == DB - 1) begin
        m_locked = 0; m_releasing = 0; m_row = (m_row + 1) % 4; m_dwell = 0;
      end else m_run++;
    end else if (m_dwell < SD - 1) m_dwell++;
    else if (cs == 4'hF) begin m_row = (m_row + 1) % 4; m_dwell = 0; end
    else begin m_trying = 1; m_cand = cs; m_run = 0; m_dwell = 0; end
    m_s2 = m_s1;
    m_s1 = c;
  endtask

  task automatic model_regs(input bit ack);
    if (m_acc) begin
      m_code = 4'(m_row * 4 + low_col(m_cand));
      m_ovf = m_pend && !ack;
      m_pend = 1;
    end else if (ack) begin
      m_pend = 0; m_ovf = 0;
    end
  endtask

  task automatic step(input bit ack_req, input bit ack_on_acc);
    logic [3:0] c;
    @(negedge clk);
    c = (kp && rows[kr] == 1'b0) ? ~(4'b0001 << kc) : 4'hF;
    cols = c;
    model_scan(c);
    rd_ack = ack_req || (ack_on_acc && m_acc);
    model_regs(rd_ack);
    @(posedge clk);
    #1;
    rd_ack = 1'b0;
    chk("rows", {4'h0, rows}, {4'h0, ~(4'b0001 << m_row)});
    chk("filtered_out", filtered_out, {m_pend, m_ovf, 2'b00, m_code});
    chk("key_down", {7'h0, key_down}, {7'h0, m_locked});
    if (key_down && !kd_prev) rises++;
    kd_prev = key_down;
  endtask

  task automatic wait_lock(input bit want, input bit ack_on_acc, input string tag);
    int n = 0;
    while (m_locked != want && n < 400) begin
      step(0, ack_on_acc);
      n++;
    end
    chk(tag, {7'h0, key_down}, {7'h0, want});
  endtask

  task automatic press(input int r, input int c);
    kr = r; kc = c; kp = 1;
    wait_lock(1, 0, "press_wait");
    repeat ($urandom_range(3, 12)) step(0, 0);
  endtask

  task automatic release_key();
    kp = 0;
    wait_lock(0, 0, "release_wait");
    repeat ($urandom_range(2, 10)) step(0, 0);
  endtask

  initial begin
    reset = 1'b1; cols = 4'hF; rd_ack = 1'b0;
    #3 reset = 1'b0;
    #1;
    chk("rst_rows", {4'h0, rows}, 8'h0E);
    chk("rst_fo", filtered_out, 8'h00);
    chk("rst_kd", {7'h0, key_down}, 8'h00);
    model_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (40) step(0, 0);

    press(2, 1);
    chk("key_89", filtered_out, 8'h89);
    chk("rows_frozen", {4'h0, rows}, 8'h0B);
    kp = 0;
    wait_lock(0, 0, "release_wait");
    chk("resume_row3", {4'h0, rows}, 8'h07);
    repeat (12) step(0, 0);

    step(1, 0);
    chk("ack_clear", filtered_out, 8'h09);
    rises = 0;
    kr = 0; kc = 0;
    for (int t = 0; t < 10; t++) begin
      kp = !kp;
      repeat (3) step(0, 0);
    end
    chk("bounce_no_accept", 8'(rises), 8'd0);
    press(0, 0);
    chk("bounce_key_80", filtered_out, 8'h80);
    release_key();
    chk("bounce_one_accept", 8'(rises), 8'd1);

    step(1, 0);
    press(1, 1);
    release_key();
    press(2, 2);
    chk("overflow_CA", filtered_out, 8'hCA);
    step(1, 0);
    chk("ack_after_ovf", filtered_out, 8'h0A);
    release_key();

    press(0, 1);
    chk("old_key_81", filtered_out, 8'h81);
    release_key();
    kr = 0; kc = 3; kp = 1;
    wait_lock(1, 1, "simul_wait");
    chk("simul_83", filtered_out, 8'h83);
    release_key();

    for (int k = 0; k < 6; k++) begin
      int r = $urandom_range(0, 3);
      press(r, $urandom_range(0, 3));
      step($urandom_range(0, 1), 0);
      release_key();
    end

    kr = 2; kc = 1; kp = 1;
    for (int n = 0; n < 400 && !(m_trying && m_run == 3); n++) step(0, 0);
    chk("mid_press_db", {7'h0, m_trying}, 8'h01);
    #2 reset = 1'b0;
    #1;
    chk("async_rows", {4'h0, rows}, 8'h0E);
    chk("async_fo", filtered_out, 8'h00);
    chk("async_kd", {7'h0, key_down}, 8'h00);
    model_reset();
    kd_prev = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    wait_lock(1, 0, "post_reset_wait");
    repeat (4) step(0, 0);
    chk("post_reset_89", filtered_out, 8'h89);
    release_key();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
